// File: rtl/regdst_pkg.sv
// Shared select encodings and default widths for the register-destination tracker.
package regdst_pkg;
  localparam logic [1:0] SEL_RT   = 2'd0;
  localparam logic [1:0] SEL_RD   = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;
  localparam logic [1:0] SEL_ALT  = 2'd3;

  localparam int ADDR_W_DEF   = 5;
  localparam int LINK_REG_DEF = 31;
endpackage

// File: rtl/regdst_sel.sv
// Combinational 4:1 write-destination selector (rt / rd / link register / alternate).
module regdst_sel
  import regdst_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic [1:0]        Sel,
  input  logic [ADDR_W-1:0] InRt,
  input  logic [ADDR_W-1:0] InRd,
  input  logic [ADDR_W-1:0] InAlt,
  output logic [ADDR_W-1:0] DstOut
);
  localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

  always_comb begin
    DstOut = InRt;
    unique case (Sel)
      SEL_RT:   DstOut = InRt;
      SEL_RD:   DstOut = InRd;
      SEL_LINK: DstOut = LINK;
      SEL_ALT:  DstOut = InAlt;
    endcase
  end
endmodule

// File: rtl/regdst_track_pipe.sv
// Selects the write destination and carries it with a valid bit through DEPTH stages,
// flagging matches against the decode sources. Define REGDST_HAZARD_EN to build the comparators.
module regdst_track_pipe
  import regdst_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [1:0]                Sel,
  input  logic [ADDR_W-1:0]         InRt,
  input  logic [ADDR_W-1:0]         InRd,
  input  logic [ADDR_W-1:0]         InAlt,
  input  logic                      RegWrite,
  input  logic                      Hold,
  input  logic                      Bubble,
  input  logic [ADDR_W-1:0]         SrcA,
  input  logic [ADDR_W-1:0]         SrcB,
  output logic [ADDR_W-1:0]         DstOut,
  output logic [DEPTH*ADDR_W-1:0]   StageDst,
  output logic [DEPTH-1:0]          StageValid,
  output logic [DEPTH-1:0]          HazardA,
  output logic [DEPTH-1:0]          HazardB
);
  logic [DEPTH-1:0][ADDR_W-1:0] stageDst;
  logic [DEPTH-1:0]             vldPipe;
  logic                         nextValid;

  regdst_sel #(.ADDR_W(ADDR_W), .LINK_REG(LINK_REG)) uSel (
    .Sel    (Sel),
    .InRt   (InRt),
    .InRd   (InRd),
    .InAlt  (InAlt),
    .DstOut (DstOut)
  );

  // Writes to $zero are architecturally discarded, so never track them as valid.
  assign nextValid = RegWrite && (DstOut != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stageDst <= '0;
      vldPipe  <= '0;
    end else if (!Hold) begin
      stageDst[0] <= Bubble ? '0 : DstOut;
      vldPipe[0]  <= !Bubble && nextValid;
      for (int i = 1; i < DEPTH; i++) begin
        stageDst[i] <= stageDst[i-1];
        vldPipe[i]  <= vldPipe[i-1];
      end
    end
  end

  assign StageDst   = stageDst;
  assign StageValid = vldPipe;

`ifdef REGDST_HAZARD_EN
  for (genvar i = 0; i < DEPTH; i++) begin : gHaz
    assign HazardA[i] = vldPipe[i] && (stageDst[i] == SrcA) && (SrcA != '0);
    assign HazardB[i] = vldPipe[i] && (stageDst[i] == SrcB) && (SrcB != '0);
  end
`else
  logic unusedSrc;
  assign unusedSrc = ^{SrcA, SrcB};
  assign HazardA   = '0;
  assign HazardB   = '0;
`endif
endmodule
